// File: rtl/wb_regfile.sv
// MIPS write-back stage plus 32-entry register file with two async read ports.
// Define WB_BYPASS_EN to make reads see a same-cycle write-back (write-through).
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoRegIN,
    input  logic              RegWriteIN,
    input  logic [DATA_W-1:0] dataIN,
    input  logic [DATA_W-1:0] ALU_IN,
    input  logic [ADDR_W-1:0] DestinoIN,
    input  logic [ADDR_W-1:0] RegA,
    input  logic [ADDR_W-1:0] RegB,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    output logic [DATA_W-1:0] WriteData,
    output logic [31:0]       WriteCount
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [31:0]       r_count;
    logic [DATA_W-1:0] w_wdata;
    logic              w_eff;

    assign w_wdata = MemtoRegIN ? dataIN : ALU_IN;
    // Writes aimed at $0 are dropped and do not count as commits.
    assign w_eff   = RegWriteIN && (DestinoIN != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_count <= '0;
        end else if (w_eff) begin
            r_regs[DestinoIN] <= w_wdata;
            r_count           <= r_count + 32'd1;
        end
    end

    always_comb begin
        DataA = '0;
        DataB = '0;
        if (RegA != '0) DataA = r_regs[RegA];
        if (RegB != '0) DataB = r_regs[RegB];
`ifdef WB_BYPASS_EN
        if (w_eff && (RegA == DestinoIN)) DataA = w_wdata;
        if (w_eff && (RegB == DestinoIN)) DataB = w_wdata;
`endif
    end

    assign WriteData  = w_wdata;
    assign WriteCount = r_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed + randomized self-checking bench for wb_regfile (honours WB_BYPASS_EN).
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoRegIN, RegWriteIN;
    logic [31:0] dataIN, ALU_IN;
    logic [4:0]  DestinoIN, RegA, RegB;
    logic [31:0] DataA, DataB, WriteData, WriteCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_count;
    logic        bypass;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .MemtoRegIN(MemtoRegIN), .RegWriteIN(RegWriteIN),
        .dataIN(dataIN), .ALU_IN(ALU_IN), .DestinoIN(DestinoIN), .RegA(RegA), .RegB(RegB),
        .DataA(DataA), .DataB(DataB), .WriteData(WriteData), .WriteCount(WriteCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read value for the model, including write-through when enabled.
    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic eff,
                                           input logic [4:0] dst, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (bypass && eff && idx == dst) return wd;
        return m_regs[idx];
    endfunction

    initial begin
`ifdef WB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        reset = 1'b1; MemtoRegIN = 1'b0; RegWriteIN = 1'b0;
        dataIN = '0; ALU_IN = '0; DestinoIN = '0; RegA = '0; RegB = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_count", WriteCount, 32'd0);
        for (int i = 0; i < 32; i++) begin
            RegA = 5'(i); RegB = 5'(31 - i);
            #1;
            check($sformatf("reset_A[%0d]", i), DataA, 32'h0);
            check($sformatf("reset_B[%0d]", 31 - i), DataB, 32'h0);
        end

        // ALU write-back to $5
        RegWriteIN = 1'b1; MemtoRegIN = 1'b0; ALU_IN = 32'h0000_1234;
        dataIN = 32'hDEAD_BEEF; DestinoIN = 5'd5;
        #1;
        check("wd_alu", WriteData, 32'h0000_1234);
        tick();
        RegWriteIN = 1'b0; RegA = 5'd5;
        #1;
        check("alu_r5", DataA, 32'h0000_1234);
        check("alu_cnt", WriteCount, 32'd1);

        // Memory write-back to $6
        RegWriteIN = 1'b1; MemtoRegIN = 1'b1; DestinoIN = 5'd6;
        #1;
        check("wd_mem", WriteData, 32'hDEAD_BEEF);
        tick();
        RegWriteIN = 1'b0; RegB = 5'd6;
        #1;
        check("mem_r6", DataB, 32'hDEAD_BEEF);
        check("mem_cnt", WriteCount, 32'd2);

        // $0 is write-protected, also against write-through
        RegWriteIN = 1'b1; MemtoRegIN = 1'b0; ALU_IN = 32'hFFFF_FFFF;
        DestinoIN = 5'd0; RegA = 5'd0;
        #1;
        check("r0_same_cycle", DataA, 32'h0);
        tick();
        RegWriteIN = 1'b0;
        #1;
        check("r0_after", DataA, 32'h0);
        check("r0_cnt", WriteCount, 32'd2);

        // RegWriteIN=0 must not write or bypass
        ALU_IN = 32'h0000_0055; DestinoIN = 5'd7; RegA = 5'd7;
        #1;
        check("nowr_same_cycle", DataA, 32'h0);
        tick();
        check("nowr_r7", DataA, 32'h0);
        check("nowr_cnt", WriteCount, 32'd2);

        // Same-cycle read of a write to $9
        RegWriteIN = 1'b1; ALU_IN = 32'hAAAA_5555; DestinoIN = 5'd9;
        RegA = 5'd9; RegB = 5'd9;
        #1;
        check("same_A", DataA, bypass ? 32'hAAAA_5555 : 32'h0);
        check("same_B", DataB, bypass ? 32'hAAAA_5555 : 32'h0);
        tick();
        RegWriteIN = 1'b0;
        #1;
        check("next_A", DataA, 32'hAAAA_5555);
        check("next_B", DataB, 32'hAAAA_5555);
        check("same_cnt", WriteCount, 32'd3);

        // Reset wins over a write on the same edge
        reset = 1'b1; RegWriteIN = 1'b1; ALU_IN = 32'h1111_1111; DestinoIN = 5'd3;
        #1;
        check("rst_wd_follows", WriteData, 32'h1111_1111);
        tick();
        reset = 1'b0; RegWriteIN = 1'b0; RegA = 5'd3; RegB = 5'd5;
        #1;
        check("coll_r3", DataA, 32'h0);
        check("coll_r5", DataB, 32'h0);
        check("coll_cnt", WriteCount, 32'd0);

        // Random traffic against a reference model
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_count = '0;
        for (int n = 0; n < 1000; n++) begin
            logic eff;
            logic [31:0] wd;
            RegWriteIN = ($urandom_range(0, 3) != 0);
            DestinoIN  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            MemtoRegIN = 1'($urandom_range(0, 1));
            dataIN     = $urandom;
            ALU_IN     = $urandom;
            RegA       = ($urandom_range(0, 3) == 0) ? DestinoIN : 5'($urandom_range(0, 31));
            RegB       = 5'($urandom_range(0, 31));
            wd  = MemtoRegIN ? dataIN : ALU_IN;
            eff = RegWriteIN && (DestinoIN != 5'd0);
            #1;
            check("rnd_A", DataA, m_read(RegA, eff, DestinoIN, wd));
            check("rnd_B", DataB, m_read(RegB, eff, DestinoIN, wd));
            tick();
            if (eff) begin
                m_regs[DestinoIN] = wd;
                m_count = m_count + 32'd1;
            end
            check("rnd_cnt", WriteCount, m_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and register file of the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs each cycle: MemtoReg, RegWrite, memory data, ALU result and destination.
- Selects the write-back value and commits it to a 32-entry register file.
- Serves the two ID-stage read ports and keeps a count of committed register writes.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W (32 entries).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- MemtoRegIN  in  1  1 selects dataIN as write-back value; 0 selects ALU_IN.
- RegWriteIN  in  1  write enable from MEM/WB.
- dataIN  in  DATA_W  data-memory read value from MEM/WB.
- ALU_IN  in  DATA_W  ALU result from MEM/WB.
- DestinoIN  in  ADDR_W  destination register index from MEM/WB.
- RegA  in  ADDR_W  read port A index (rs) from ID.
- RegB  in  ADDR_W  read port B index (rt) from ID.
- DataA  out  DATA_W  read port A value.
- DataB  out  DATA_W  read port B value.
- WriteData  out  DATA_W  current write-back value, sent to the forwarding unit.
- WriteCount  out  32  number of committed register writes.

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.

Write-back value:
- WriteData = MemtoRegIN ? dataIN : ALU_IN.
- Purely combinational; independent of reset and RegWriteIN.

Commit:
- A write is "effective" when RegWriteIN=1 and DestinoIN!=0.
- On a rising clk edge with reset=0 and an effective write: regs[DestinoIN] <= WriteData.
- On that same edge, WriteCount <= WriteCount+1. The count wraps from 0xFFFFFFFF to 0.
- RegWriteIN=1 with DestinoIN=0 is discarded. regs[0] is unchanged and WriteCount does not increment.
- RegWriteIN=0: no state change.

Reset:
- On a rising clk edge with reset=1, all 32 registers clear to 0 and WriteCount clears to 0.
- Reset has priority over a write presented on the same edge; that write is lost.
- Reset asserted mid-program discards the in-flight write-back.
- After reset deasserts, operation resumes on the next edge with no recovery cycles.

Reads:
- Asynchronous (combinational) from the array.
- Index 0 always reads 0, regardless of array contents.
- Both ports may read the same index simultaneously.

Latency:
- Write-to-read latency is one clock without the optional feature. The read in the writing cycle returns the old value; the read in the next cycle returns the new one.

Outputs during and after reset:
- DataA/DataB read 0 for every index.
- WriteCount = 0.
- WriteData still follows its inputs.

No stalls or handshakes:
- The block accepts one write-back per cycle unconditionally.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: same-cycle write-through.
  - If an effective write is present and RegA==DestinoIN, DataA = WriteData in that same cycle. DataB behaves the same with RegB.
  - Index 0 still reads 0.
  - Removes the WB->ID hazard, so ID can read a value in the cycle it is written back.
- Undefined: reads return array contents only; the pipeline must stall or forward externally.
- Commit and counter behaviour are identical either way.

Test Plan:
- Reset: hold reset=1 for 2 cycles, then sweep RegA/RegB over 0..31 -> DataA=DataB=0 and WriteCount=0.
- ALU write-back: RegWriteIN=1, MemtoRegIN=0, ALU_IN=0x0000_1234, dataIN=0xDEAD_BEEF, DestinoIN=5 for one edge -> next cycle RegA=5 gives DataA=0x0000_1234 and WriteCount=1. Repeat with MemtoRegIN=1, DestinoIN=6 -> RegB=6 gives DataB=0xDEAD_BEEF and WriteCount=2.
- $0 protection: RegWriteIN=1, DestinoIN=0, ALU_IN=0xFFFF_FFFF -> RegA=0 reads 0 and WriteCount is unchanged. RegWriteIN=0, DestinoIN=7 -> regs[7] is unchanged.
- Same-cycle read of a write: write 0xAAAA_5555 to register 9 while RegA=RegB=9 -> with WB_BYPASS_EN, DataA=DataB=0xAAAA_5555 in that cycle; without it, both show the old value (0) in that cycle and 0xAAAA_5555 in the next.
- Reset collision: reset=1 on the same edge as an effective write of 0x1111_1111 to register 3 -> regs[3]=0 and WriteCount=0.
- Counter wrap: 2**32 effective writes are not feasible in simulation, so the bench starts from 0 and checks monotonic +1 over 1000 random writes with ~25% DestinoIN=0 and ~25% RegWriteIN=0. WriteCount must equal the number of effective writes. Wrap from 0xFFFFFFFF to 0 is covered by a formal assertion or by force-loading the counter.
